// File: rtl/dense_addr_loop.sv
// DENSE-layer address loop: walks n/m/k and emits {input, weight, output} address tuples.
// Optional iteration counter output enabled by defining DENSE_LOOP_ITER_COUNT_EN.
module dense_addr_loop #(
  parameter int ADDR_BITS = 32,
  parameter int SIZE_BITS = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_ready_in,
  input  logic                 next_ready_in,
  input  logic [ADDR_BITS-1:0] input_base_addr,
  input  logic [ADDR_BITS-1:0] weight_base_addr,
  input  logic [ADDR_BITS-1:0] output_base_addr,
  input  logic [SIZE_BITS-1:0] m_size,
  input  logic [SIZE_BITS-1:0] chw_size,
  input  logic [SIZE_BITS-1:0] n_size,
  output logic [ADDR_BITS-1:0] input_addr,
  output logic [ADDR_BITS-1:0] weight_addr,
  output logic [ADDR_BITS-1:0] output_addr,
  output logic                 ready_out,
  output logic                 last_k_out,
  output logic                 done_out
`ifdef DENSE_LOOP_ITER_COUNT_EN
  ,
  output logic [3*SIZE_BITS-1:0] iter_count_out
`endif
);

  localparam logic [SIZE_BITS-1:0]   SIZE_ONE = SIZE_BITS'(1);
  localparam logic [ADDR_BITS-1:0]   ADDR_ONE = ADDR_BITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [SIZE_BITS-1:0] r_k, r_m, r_n;
  logic [SIZE_BITS-1:0] r_m_size, r_chw_size, r_n_size;
  logic [ADDR_BITS-1:0] r_w_base, r_in_row;
  logic [ADDR_BITS-1:0] r_in_addr, r_w_addr, r_out_addr;

  logic                 w_size_zero;
  logic                 w_consume;
  logic                 w_last_k, w_last_m, w_last_n;
  logic [ADDR_BITS-1:0] w_chw_ext;
  logic [ADDR_BITS-1:0] w_next_row;

  assign w_size_zero = (m_size == '0) || (chw_size == '0) || (n_size == '0);
  // Start outranks next, so a consume never lands on a restart cycle.
  assign w_consume   = (r_state == S_RUN) && next_ready_in && !start_ready_in;
  assign w_last_k    = (r_k == r_chw_size - SIZE_ONE);
  assign w_last_m    = (r_m == r_m_size - SIZE_ONE);
  assign w_last_n    = (r_n == r_n_size - SIZE_ONE);
  assign w_chw_ext   = ADDR_BITS'(r_chw_size);
  assign w_next_row  = r_in_row + w_chw_ext;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start_ready_in) begin
      w_state_next = w_size_zero ? S_DONE : S_RUN;
    end else if (w_consume && w_last_k && w_last_m && w_last_n) begin
      w_state_next = S_DONE;
    end
  end

  always_comb begin
    ready_out  = (r_state == S_RUN);
    done_out   = (r_state == S_DONE);
    last_k_out = (r_state == S_RUN) && w_last_k;
  end

  // Incremental address walk: only adders, row bases carried in registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_k        <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_m_size   <= '0;
      r_chw_size <= '0;
      r_n_size   <= '0;
      r_w_base   <= '0;
      r_in_row   <= '0;
      r_in_addr  <= '0;
      r_w_addr   <= '0;
      r_out_addr <= '0;
    end else if (start_ready_in) begin
      r_k        <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_m_size   <= m_size;
      r_chw_size <= chw_size;
      r_n_size   <= n_size;
      r_w_base   <= weight_base_addr;
      r_in_row   <= input_base_addr;
      r_in_addr  <= input_base_addr;
      r_w_addr   <= weight_base_addr;
      r_out_addr <= output_base_addr;
    end else if (w_consume) begin
      if (!w_last_k) begin
        r_k       <= r_k + SIZE_ONE;
        r_in_addr <= r_in_addr + ADDR_ONE;
        r_w_addr  <= r_w_addr + ADDR_ONE;
      end else if (!w_last_m) begin
        r_k        <= '0;
        r_m        <= r_m + SIZE_ONE;
        r_in_addr  <= r_in_row;
        r_w_addr   <= r_w_addr + ADDR_ONE;
        r_out_addr <= r_out_addr + ADDR_ONE;
      end else begin
        r_k        <= '0;
        r_m        <= '0;
        r_n        <= r_n + SIZE_ONE;
        r_in_row   <= w_next_row;
        r_in_addr  <= w_next_row;
        r_w_addr   <= r_w_base;
        r_out_addr <= r_out_addr + ADDR_ONE;
      end
    end
  end

  assign input_addr  = r_in_addr;
  assign weight_addr = r_w_addr;
  assign output_addr = r_out_addr;

`ifdef DENSE_LOOP_ITER_COUNT_EN
  localparam logic [3*SIZE_BITS-1:0] CNT_ONE = (3*SIZE_BITS)'(1);
  logic [3*SIZE_BITS-1:0] r_iter_count;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_iter_count <= '0;
    end else if (start_ready_in) begin
      r_iter_count <= '0;
    end else if (w_consume) begin
      r_iter_count <= r_iter_count + CNT_ONE;
    end
  end

  assign iter_count_out = r_iter_count;
`endif

endmodule

// File: tb/tb_dense_addr_loop.sv
// Directed bench for dense_addr_loop: a reference model fills a tuple queue at each start,
// and every presented tuple is compared against the queue head (popped when consumed).
module tb_dense_addr_loop;
  localparam int AB = 32;
  localparam int SB = 10;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_ready_in = 1'b0;
  logic          next_ready_in = 1'b0;
  logic [AB-1:0] input_base_addr = '0;
  logic [AB-1:0] weight_base_addr = '0;
  logic [AB-1:0] output_base_addr = '0;
  logic [SB-1:0] m_size = '0;
  logic [SB-1:0] chw_size = '0;
  logic [SB-1:0] n_size = '0;
  logic [AB-1:0] input_addr, weight_addr, output_addr;
  logic          ready_out, last_k_out, done_out;
`ifdef DENSE_LOOP_ITER_COUNT_EN
  logic [3*SB-1:0] iter_count_out;
`endif

  dense_addr_loop #(.ADDR_BITS(AB), .SIZE_BITS(SB)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_ready_in   (start_ready_in),
    .next_ready_in    (next_ready_in),
    .input_base_addr  (input_base_addr),
    .weight_base_addr (weight_base_addr),
    .output_base_addr (output_base_addr),
    .m_size           (m_size),
    .chw_size         (chw_size),
    .n_size           (n_size),
    .input_addr       (input_addr),
    .weight_addr      (weight_addr),
    .output_addr      (output_addr),
    .ready_out        (ready_out),
    .last_k_out       (last_k_out),
    .done_out         (done_out)
`ifdef DENSE_LOOP_ITER_COUNT_EN
    ,
    .iter_count_out   (iter_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [AB-1:0] ia;
    logic [AB-1:0] wa;
    logic [AB-1:0] oa;
    logic          lk;
  } tuple_t;

  tuple_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_model(input logic [AB-1:0] ib, input logic [AB-1:0] wb, input logic [AB-1:0] ob,
                            input int msz, input int chw, input int nsz);
    tuple_t t;
    for (int n = 0; n < nsz; n++)
      for (int m = 0; m < msz; m++)
        for (int k = 0; k < chw; k++) begin
          t.ia = ib + AB'(n * chw + k);
          t.wa = wb + AB'(m * chw + k);
          t.oa = ob + AB'(n * msz + m);
          t.lk = (k == chw - 1);
          exp_q.push_back(t);
        end
  endtask

  // Drives a one-cycle start from a negedge; afterwards scrambles the size inputs
  // so any use of unlatched sizes shows up as a wrong tuple.
  task automatic do_start(input logic [AB-1:0] ib, input logic [AB-1:0] wb, input logic [AB-1:0] ob,
                          input int msz, input int chw, input int nsz);
    input_base_addr  = ib;
    weight_base_addr = wb;
    output_base_addr = ob;
    m_size           = SB'(msz);
    chw_size         = SB'(chw);
    n_size           = SB'(nsz);
    start_ready_in   = 1'b1;
    exp_q.delete();
    push_model(ib, wb, ob, msz, chw, nsz);
    $display("start m=%0d chw=%0d n=%0d tuples=%0d", msz, chw, nsz, exp_q.size());
    @(negedge clk_in);
    start_ready_in   = 1'b0;
    m_size           = SB'(7);
    chw_size         = SB'(5);
    n_size           = SB'(9);
    input_base_addr  = 32'hDEAD_0000;
  endtask

  task automatic consume(input bit toggle, input int max_pops, input int budget);
    int     cyc = 0;
    int     pops = 0;
    tuple_t t;
    while (exp_q.size() > 0 && pops < max_pops && cyc < budget) begin
      t = exp_q[0];
      chk("ready", 64'(ready_out), 64'(1'b1));
      chk("in_addr", 64'(input_addr), 64'(t.ia));
      chk("w_addr", 64'(weight_addr), 64'(t.wa));
      chk("out_addr", 64'(output_addr), 64'(t.oa));
      chk("last_k", 64'(last_k_out), 64'(t.lk));
      next_ready_in = toggle ? (cyc % 2 == 0) : 1'b1;
      if (next_ready_in) begin
        $display("tuple in=%0h w=%0h out=%0h last_k=%0b", input_addr, weight_addr, output_addr, last_k_out);
        void'(exp_q.pop_front());
        pops++;
      end
      cyc++;
      @(negedge clk_in);
    end
    if (cyc >= budget) begin
      checks++;
      errors++;
      $error("FAIL consume_timeout observed=%0d cycles expected<%0d", cyc, budget);
    end
    if (exp_q.size() == 0) next_ready_in = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, 64'(done_out), 64'(1'b1));
    chk({tag, "_ready"}, 64'(ready_out), 64'(1'b0));
    chk({tag, "_last_k"}, 64'(last_k_out), 64'(1'b0));
  endtask

  initial begin
    @(negedge clk_in);
    chk("rst_ready", 64'(ready_out), 64'(1'b0));
    chk("rst_done", 64'(done_out), 64'(1'b0));
    chk("rst_last_k", 64'(last_k_out), 64'(1'b0));
    chk("rst_in_addr", 64'(input_addr), 64'h0);
    chk("rst_w_addr", 64'(weight_addr), 64'h0);
    chk("rst_out_addr", 64'(output_addr), 64'h0);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("idle_ready", 64'(ready_out), 64'(1'b0));

    // Basic loop, next held high
    do_start(32'h100, 32'h200, 32'h300, 2, 3, 1);
    consume(1'b0, 1000, 50);
    check_done("t1");
    @(negedge clk_in);
    check_done("t1_hold");

    // Two batch rows
    do_start(32'h100, 32'h200, 32'h300, 1, 2, 2);
    consume(1'b0, 1000, 50);
    check_done("t2");

    // Zero size: straight to DONE
    do_start(32'h100, 32'h200, 32'h300, 2, 0, 1);
    check_done("t3");
    @(negedge clk_in);
    check_done("t3_hold");

    // Stalled consumption
    do_start(32'h100, 32'h200, 32'h300, 2, 3, 1);
    consume(1'b1, 1000, 50);
    check_done("t4");

    // Restart mid-loop; next_ready_in is still high on the start cycle
    do_start(32'h100, 32'h200, 32'h300, 2, 3, 1);
    consume(1'b0, 2, 20);
    do_start(32'h100, 32'h200, 32'h300, 2, 3, 1);
    consume(1'b0, 1000, 50);
    check_done("t5");

    // Asynchronous reset mid-run
    do_start(32'h100, 32'h200, 32'h300, 2, 3, 1);
    consume(1'b0, 2, 20);
    next_ready_in = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk("arst_ready", 64'(ready_out), 64'(1'b0));
    chk("arst_done", 64'(done_out), 64'(1'b0));
    chk("arst_in_addr", 64'(input_addr), 64'h0);
    exp_q.delete();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("post_rst_ready", 64'(ready_out), 64'(1'b0));
    chk("post_rst_done", 64'(done_out), 64'(1'b0));

    // Larger loop; iteration count where present
    do_start(32'h100, 32'h200, 32'h300, 2, 3, 2);
    consume(1'b0, 1000, 50);
    check_done("t7");
`ifdef DENSE_LOOP_ITER_COUNT_EN
    chk("iter_final", 64'(iter_count_out), 64'd12);
`endif
    do_start(32'hFFFF_FFFE, 32'h200, 32'h300, 1, 3, 1);
`ifdef DENSE_LOOP_ITER_COUNT_EN
    chk("iter_cleared", 64'(iter_count_out), 64'd0);
`endif
    consume(1'b0, 1000, 50);
    check_done("t8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dense_addr_loop.md
Name: dense_addr_loop

Overview:
- Address-generating loop engine for DENSE layers. It is the responder to the layer controller's loop handshake.
- Walks n (outer), m (middle) and k over chw (inner), and issues one {input, weight, output} address tuple per MAC step.
- Sits between the layer controller and the BRAM scratchpads. The controller consumes tuples via next_ready_in; this block advances and flags completion.
- Uses incremental adders only; no multipliers.

Parameters:
ADDR_BITS, 32, width of all base and generated addresses
SIZE_BITS, 10, width of m/chw/n size inputs and loop counters

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-low
start_ready_in  input  1  1-cycle pulse: latch bases/sizes, restart loop
next_ready_in  input  1  consume current tuple; ignored unless ready_out=1
input_base_addr  input  ADDR_BITS  input activation base
weight_base_addr  input  ADDR_BITS  weight matrix base (row-major [m][chw])
output_base_addr  input  ADDR_BITS  output base (row-major [n][m])
m_size  input  SIZE_BITS  output features
chw_size  input  SIZE_BITS  input features
n_size  input  SIZE_BITS  batch count
input_addr  output  ADDR_BITS  input_base + n*chw_size + k
weight_addr  output  ADDR_BITS  weight_base + m*chw_size + k
output_addr  output  ADDR_BITS  output_base + n*m_size + m
ready_out  output  1  current tuple valid
last_k_out  output  1  current tuple has k == chw_size-1 (accumulation chain end)
done_out  output  1  all tuples consumed; held until next start

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE. All addresses 0; ready_out, last_k_out and done_out 0; counters 0. Reset mid-loop aborts with no further tuples.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start_ready_in=1:
  - Latch bases and sizes; zero k, m, n.
  - If any size is 0: next cycle DONE with done_out=1 and no tuple issued.
  - Otherwise: next cycle RUN with ready_out=1 and tuple (0,0,0). Start-to-first-tuple latency is 1 cycle.
- In RUN, a simultaneous next_ready_in on the start cycle is ignored.
- RUN, ready_out=1, no next_ready_in: hold all outputs stable.
- RUN + next_ready_in=1:
  - Next cycle presents the next tuple; ready_out stays 1, giving 1 tuple/cycle throughput.
  - k increments; input_addr+1, weight_addr+1.
  - k wrap (k==chw-1): k=0, m+1. input_addr returns to the row base n*chw; weight_addr continues +1 (contiguous); output_addr+1.
  - m wrap (m==m_size-1): m=0, n+1. Input row base += chw_size and input_addr takes the new row base; weight_addr returns to weight_base; output_addr+1.
  - Final tuple consumed (k, m, n all at last): next cycle DONE, ready_out=0, done_out=1.
- start_ready_in in RUN: abort current loop, restart exactly as from IDLE (start has priority over next_ready_in).
- last_k_out is combinational from k==chw_size-1 and is qualified by ready_out.
- Address arithmetic is modulo 2^ADDR_BITS (wraps silently). Counters compare using latched sizes, so input size changes after start have no effect.
- done_out stays high in DONE until the next start_ready_in (cleared the cycle after start) or reset.

Optional Feature:
- Macro DENSE_LOOP_ITER_COUNT_EN.
- Defined: adds output iter_count_out [3*SIZE_BITS-1:0].
  - Cleared on start.
  - Increments on each consumed tuple.
  - Holds its final value (n*m*chw) in DONE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Bases in=0x100, w=0x200, out=0x300; m=2, chw=3, n=1; next_ready_in held high -> tuples (in,w,out) in order: (100,200,300), (101,201,300), (102,202,300), (100,203,301), (101,204,301), (102,205,301). last_k_out on the 3rd and 6th tuples; done_out 1 cycle after the 6th.
- Same bases, m=1, chw=2, n=2 -> (100,200,300), (101,201,300), (102,200,301), (103,201,301); then done.
- chw=0 (others nonzero) with start -> done_out=1 next cycle, ready_out never asserts.
- m=2, chw=3, n=1 with next_ready_in toggled every other cycle -> outputs stable while stalled; same 6-tuple sequence; no skips or duplicates.
- Restart: start, consume 2 tuples, pulse start again -> next cycle tuple (100,200,300). rst_in low mid-RUN -> ready_out and done_out drop to 0 immediately (asynchronous).
- DENSE_LOOP_ITER_COUNT_EN with m=2, chw=3, n=2 -> iter_count_out=12 in DONE; 0 the cycle after the next start.
